// File: rtl/voice_allocator_if.sv
// ---------------------------------------------------------------------------
// voice_allocator_if
// Note-request handshake between the MIDI event front end and the voice
// allocator.
//   req_valid : note request present
//   req_ready : allocator can accept a request
//   req_on    : 1 = note-on, 0 = note-off
//   req_key   : MIDI key number
//   req_vel   : velocity
// master = request source, slave = voice_allocator.
// ---------------------------------------------------------------------------
interface voice_allocator_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_on;
    logic [6:0] req_key;
    logic [7:0] req_vel;

    modport master (output req_valid, output req_on, output req_key, output req_vel,
                    input  req_ready);
    modport slave  (input  req_valid, input  req_on, input  req_key, input  req_vel,
                    output req_ready);
endinterface

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
// Maps note-on/note-off requests onto VOICES synth voices. Each accepted
// request scans every voice (one per cycle) and then issues one registered
// event: retrigger the same key, else a free voice, else the oldest released
// voice, else steal the oldest held voice.
// Ports:
//   sysclk, reset1 : clock, asynchronous active-low reset
//   req_if         : request handshake (slave side)
//   clr_all        : all-notes-off pulse (deferred to IDLE if busy)
//   voice_free     : per-voice envelope-finished flags, sampled live in SCAN
//   ev_*           : one-cycle voice event (data fields hold between events)
//   off_miss       : one-cycle pulse, note-off matched no held voice
//   keys_on        : per-voice key-held flags
//   active_keys    : popcount of keys_on, one cycle behind
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = $clog2(VOICES)
) (
    input  logic                sysclk,
    input  logic                reset1,
    voice_allocator_if.slave    req_if,
    input  logic                clr_all,
    input  logic [VOICES-1:0]   voice_free,
    output logic                ev_valid,
    output logic                ev_on,
    output logic [V_WIDTH-1:0]  ev_voice,
    output logic [6:0]          ev_key,
    output logic [7:0]          ev_vel,
    output logic                ev_steal,
    output logic                off_miss,
    output logic [VOICES-1:0]   keys_on,
    output logic [V_WIDTH:0]    active_keys
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, ISSUE = 2'd2} state_t;

    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

    state_t               state_r;
    logic                 ready_r;
    logic                 clr_pend_r;
    logic [V_WIDTH-1:0]   idx_r;
    logic                 req_on_r;
    logic [6:0]           req_key_r;
    logic [7:0]           req_vel_r;
    logic [6:0]           key_r [VOICES];
    logic [7:0]           age_r [VOICES];
    logic [VOICES-1:0]    keys_on_r;

    // Running candidates: match, free, released-oldest, held-oldest
    logic                 m_found_r, f_found_r, r_found_r, h_found_r;
    logic [V_WIDTH-1:0]   m_idx_r, f_idx_r, r_idx_r, h_idx_r;
    logic [7:0]           r_age_r, h_age_r;

    logic                 m_found_s, f_found_s, r_found_s, h_found_s;
    logic [V_WIDTH-1:0]   m_idx_s, f_idx_s, r_idx_s, h_idx_s;
    logic [7:0]           r_age_s, h_age_s;
    logic                 cur_held_s, cur_free_s;
    logic [7:0]           cur_age_s;
    logic [V_WIDTH-1:0]   pick_s;
    logic                 hit_s, steal_s;
    logic [V_WIDTH:0]     cnt_s;

    // A clr_all on the input masks ready immediately so no request slips past it
    assign req_if.req_ready = ready_r & ~clr_all;
    assign keys_on          = keys_on_r;

    // Fold the voice under the scan index into the running candidates
    always_comb begin
        cur_held_s = keys_on_r[idx_r];
        cur_free_s = voice_free[idx_r];
        cur_age_s  = age_r[idx_r];
        m_found_s = m_found_r; m_idx_s = m_idx_r;
        f_found_s = f_found_r; f_idx_s = f_idx_r;
        r_found_s = r_found_r; r_idx_s = r_idx_r; r_age_s = r_age_r;
        h_found_s = h_found_r; h_idx_s = h_idx_r; h_age_s = h_age_r;
        if (cur_held_s && (key_r[idx_r] == req_key_r) && !m_found_r) begin
            m_found_s = 1'b1; m_idx_s = idx_r;
        end else begin
            m_found_s = m_found_r;
        end
        if (!cur_held_s && cur_free_s && !f_found_r) begin
            f_found_s = 1'b1; f_idx_s = idx_r;
        end else begin
            f_found_s = f_found_r;
        end
        // Strict '>' keeps the lowest index on equal ages
        if (!cur_held_s && !cur_free_s && (!r_found_r || (cur_age_s > r_age_r))) begin
            r_found_s = 1'b1; r_idx_s = idx_r; r_age_s = cur_age_s;
        end else begin
            r_found_s = r_found_r;
        end
        if (cur_held_s && (!h_found_r || (cur_age_s > h_age_r))) begin
            h_found_s = 1'b1; h_idx_s = idx_r; h_age_s = cur_age_s;
        end else begin
            h_found_s = h_found_r;
        end
    end

    // Final voice choice, valid during the last SCAN cycle
    always_comb begin
        pick_s  = m_idx_s;
        hit_s   = m_found_s;
        steal_s = 1'b0;
        if (req_on_r) begin
            hit_s = 1'b1;
            if (m_found_s) begin
                pick_s = m_idx_s;
            end else if (f_found_s) begin
                pick_s = f_idx_s;
            end else if (r_found_s) begin
                pick_s = r_idx_s;
            end else begin
                pick_s  = h_idx_s;
                steal_s = 1'b1;
            end
        end else begin
            hit_s  = m_found_s;
            pick_s = m_idx_s;
        end
    end

    // Popcount of held flags
    always_comb begin
        cnt_s = '0;
        for (int i = 0; i < VOICES; i++) begin
            cnt_s = cnt_s + {{V_WIDTH{1'b0}}, keys_on_r[i]};
        end
    end

    // Control FSM, per-voice state and registered event outputs
    always_ff @(posedge sysclk or negedge reset1) begin
        if (!reset1) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            clr_pend_r  <= 1'b0;
            idx_r       <= '0;
            req_on_r    <= 1'b0;
            req_key_r   <= 7'd0;
            req_vel_r   <= 8'd0;
            keys_on_r   <= '0;
            m_found_r   <= 1'b0; f_found_r <= 1'b0; r_found_r <= 1'b0; h_found_r <= 1'b0;
            m_idx_r     <= '0;   f_idx_r   <= '0;   r_idx_r   <= '0;   h_idx_r   <= '0;
            r_age_r     <= 8'd0; h_age_r   <= 8'd0;
            ev_valid    <= 1'b0;
            ev_on       <= 1'b0;
            ev_voice    <= '0;
            ev_key      <= 7'd0;
            ev_vel      <= 8'd0;
            ev_steal    <= 1'b0;
            off_miss    <= 1'b0;
            active_keys <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_r[i] <= 7'd0;
                age_r[i] <= 8'd0;
            end
        end else begin
            ev_valid    <= 1'b0;
            ev_steal    <= 1'b0;
            off_miss    <= 1'b0;
            active_keys <= cnt_s;
            case (state_r)
                IDLE: begin
                    if (clr_all || clr_pend_r) begin
                        keys_on_r  <= '0;
                        clr_pend_r <= 1'b0;
                        ready_r    <= 1'b1;
                    end else if (req_if.req_valid && ready_r) begin
                        // Zero velocity note-on is a note-off by MIDI convention
                        req_on_r  <= req_if.req_on && (req_if.req_vel != 8'd0);
                        req_key_r <= req_if.req_key;
                        req_vel_r <= req_if.req_vel;
                        idx_r     <= '0;
                        m_found_r <= 1'b0; f_found_r <= 1'b0;
                        r_found_r <= 1'b0; h_found_r <= 1'b0;
                        ready_r   <= 1'b0;
                        state_r   <= SCAN;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                SCAN: begin
                    m_found_r <= m_found_s; m_idx_r <= m_idx_s;
                    f_found_r <= f_found_s; f_idx_r <= f_idx_s;
                    r_found_r <= r_found_s; r_idx_r <= r_idx_s; r_age_r <= r_age_s;
                    h_found_r <= h_found_s; h_idx_r <= h_idx_s; h_age_r <= h_age_s;
                    if (clr_all) begin
                        clr_pend_r <= 1'b1;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= ISSUE;
                        // Commit on the edge into ISSUE so ev_* is valid for the ISSUE cycle
                        if (req_on_r) begin
                            for (int i = 0; i < VOICES; i++) begin
                                if (V_WIDTH'(i) == pick_s) begin
                                    age_r[i]     <= 8'd0;
                                    key_r[i]     <= req_key_r;
                                    keys_on_r[i] <= 1'b1;
                                end else if (age_r[i] != 8'd255) begin
                                    age_r[i] <= age_r[i] + 8'd1;
                                end else begin
                                    age_r[i] <= age_r[i];
                                end
                            end
                        end else if (m_found_s) begin
                            keys_on_r[m_idx_s] <= 1'b0;
                        end
                        if (hit_s) begin
                            ev_valid <= 1'b1;
                            ev_on    <= req_on_r;
                            ev_voice <= pick_s;
                            ev_key   <= req_key_r;
                            ev_vel   <= req_vel_r;
                            ev_steal <= steal_s;
                        end else begin
                            off_miss <= 1'b1;
                        end
                    end else begin
                        idx_r <= idx_r + V_WIDTH'(1'b1);
                    end
                end
                ISSUE: begin
                    state_r <= IDLE;
                    ready_r <= !(clr_all || clr_pend_r);
                    if (clr_all) begin
                        clr_pend_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_voice_allocator
// Directed and randomized bench for voice_allocator (VOICES = 4). A
// behavioural model (held/key/age arrays with the selection rules applied
// directly) predicts every event; each scenario task compares inline.
// ---------------------------------------------------------------------------
module tb_voice_allocator;
    localparam int VOICES = 4;
    localparam int VW     = 2;

    logic              sysclk = 1'b0;
    logic              reset1;
    logic              clr_all;
    logic [VOICES-1:0] vf;
    logic              ev_valid, ev_on, ev_steal, off_miss;
    logic [VW-1:0]     ev_voice;
    logic [6:0]        ev_key;
    logic [7:0]        ev_vel;
    logic [VOICES-1:0] keys_on;
    logic [VW:0]       active_keys;

    int n_checks = 0;
    int n_pass   = 0;

    bit m_held [VOICES];
    int m_key  [VOICES];
    int m_age  [VOICES];

    voice_allocator_if rif ();

    voice_allocator #(.VOICES(VOICES)) dut (
        .sysclk      (sysclk),
        .reset1      (reset1),
        .req_if      (rif),
        .clr_all     (clr_all),
        .voice_free  (vf),
        .ev_valid    (ev_valid),
        .ev_on       (ev_on),
        .ev_voice    (ev_voice),
        .ev_key      (ev_key),
        .ev_vel      (ev_vel),
        .ev_steal    (ev_steal),
        .off_miss    (off_miss),
        .keys_on     (keys_on),
        .active_keys (active_keys)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int count_held();
        int c = 0;
        for (int i = 0; i < VOICES; i++) c += int'(m_held[i]);
        return c;
    endfunction

    function automatic logic [VOICES-1:0] held_vec();
        logic [VOICES-1:0] r = '0;
        for (int i = 0; i < VOICES; i++) r[i] = m_held[i];
        return r;
    endfunction

    // Oldest voice in a category: held voices, or released (not held, not free).
    function automatic int oldest(input bit want_held, input logic [VOICES-1:0] fr);
        int best = -1;
        for (int i = 0; i < VOICES; i++)
            if ((want_held ? m_held[i] : (!m_held[i] && !fr[i])) && m_age[i] > best) best = m_age[i];
        for (int i = 0; i < VOICES; i++)
            if ((want_held ? m_held[i] : (!m_held[i] && !fr[i])) && m_age[i] == best) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VOICES; i++) begin
            m_held[i] = 1'b0; m_key[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset1 = 1'b0; clr_all = 1'b0; vf = 4'b1111;
        rif.req_valid = 1'b0; rif.req_on = 1'b0; rif.req_key = 7'd0; rif.req_vel = 8'd0;
        model_reset();
        repeat (2) @(negedge sysclk);
        reset1 = 1'b1;
        @(negedge sysclk);
    endtask

    // One request end to end; clr_at >= 0 pulses clr_all in that scan cycle.
    task automatic send(input bit on, input logic [6:0] k, input logic [7:0] v, input int clr_at);
        int w, mi, fi, ri, hi, ch, old_cnt, new_cnt;
        bit on_eff, exp_ev, exp_miss, exp_steal;
        logic [VW-1:0] exp_v;
        w = 0;
        while (rif.req_ready !== 1'b1 && w < 20) begin @(negedge sysclk); w++; end
        n_checks++; if (rif.req_ready !== 1'b1) $display("FAIL ready_wait: got %b expected 1", rif.req_ready); else n_pass++;
        // reference model
        on_eff = on && (v != 8'd0);
        old_cnt = count_held();
        mi = -1; fi = -1;
        for (int i = 0; i < VOICES; i++) begin
            if (mi < 0 && m_held[i] && m_key[i] == int'(k)) mi = i;
            if (fi < 0 && !m_held[i] && vf[i]) fi = i;
        end
        ri = oldest(1'b0, vf);
        hi = oldest(1'b1, vf);
        exp_steal = 1'b0; exp_miss = 1'b0; exp_ev = 1'b1; ch = mi;
        if (on_eff) begin
            if (mi >= 0) ch = mi;
            else if (fi >= 0) ch = fi;
            else if (ri >= 0) ch = ri;
            else begin ch = hi; exp_steal = 1'b1; end
            for (int i = 0; i < VOICES; i++) m_age[i] = (i == ch) ? 0 : ((m_age[i] < 255) ? m_age[i] + 1 : 255);
            m_held[ch] = 1'b1; m_key[ch] = int'(k);
        end else if (mi >= 0) begin
            m_held[mi] = 1'b0;
        end else begin
            exp_ev = 1'b0; exp_miss = 1'b1; ch = 0;
        end
        exp_v = VW'(ch);
        new_cnt = count_held();
        // drive and track
        rif.req_valid = 1'b1; rif.req_on = on; rif.req_key = k; rif.req_vel = v;
        @(posedge sysclk);
        @(negedge sysclk);
        rif.req_valid = 1'b0; rif.req_on = 1'($urandom); rif.req_key = 7'($urandom); rif.req_vel = 8'($urandom);
        for (int c = 0; c < VOICES; c++) begin
            clr_all = (c == clr_at);
            if (c == VOICES - 1) begin
                n_checks++; if (ev_valid !== 1'b0) $display("FAIL early_ev: got %b expected 0", ev_valid); else n_pass++;
            end else begin
                @(negedge sysclk);
            end
        end
        @(negedge sysclk);
        clr_all = 1'b0;
        n_checks++; if (ev_valid !== exp_ev) $display("FAIL ev_valid: got %b expected %b key %0d", ev_valid, exp_ev, k); else n_pass++;
        n_checks++; if (off_miss !== exp_miss) $display("FAIL off_miss: got %b expected %b", off_miss, exp_miss); else n_pass++;
        n_checks++; if (keys_on !== held_vec()) $display("FAIL keys_on: got %b expected %b", keys_on, held_vec()); else n_pass++;
        n_checks++; if (active_keys !== 3'(old_cnt)) $display("FAIL active_lag: got %0d expected %0d", active_keys, old_cnt); else n_pass++;
        if (exp_ev) begin
            n_checks++; if (ev_on !== on_eff) $display("FAIL ev_on: got %b expected %b", ev_on, on_eff); else n_pass++;
            n_checks++; if (ev_voice !== exp_v) $display("FAIL ev_voice: got %0d expected %0d", ev_voice, exp_v); else n_pass++;
            n_checks++; if (ev_key !== k) $display("FAIL ev_key: got %0d expected %0d", ev_key, k); else n_pass++;
            n_checks++; if (ev_vel !== v) $display("FAIL ev_vel: got %0d expected %0d", ev_vel, v); else n_pass++;
            n_checks++; if (ev_steal !== exp_steal) $display("FAIL ev_steal: got %b expected %b", ev_steal, exp_steal); else n_pass++;
        end
        @(negedge sysclk);
        n_checks++; if ((ev_valid | off_miss) !== 1'b0) $display("FAIL strobe_len: got %b%b expected 00", ev_valid, off_miss); else n_pass++;
        n_checks++; if (active_keys !== 3'(new_cnt)) $display("FAIL active_keys: got %0d expected %0d", active_keys, new_cnt); else n_pass++;
        n_checks++; if (rif.req_ready !== (clr_at < 0)) $display("FAIL ready_idle: got %b expected %b", rif.req_ready, clr_at < 0); else n_pass++;
        if (clr_at >= 0) begin
            model_reset_held();
            @(negedge sysclk);
            n_checks++; if (keys_on !== '0) $display("FAIL clr_keys: got %b expected 0000", keys_on); else n_pass++;
            n_checks++; if (rif.req_ready !== 1'b1) $display("FAIL clr_ready: got %b expected 1", rif.req_ready); else n_pass++;
            @(negedge sysclk);
            n_checks++; if (active_keys !== 3'd0) $display("FAIL clr_active: got %0d expected 0", active_keys); else n_pass++;
        end
    endtask

    task automatic model_reset_held();
        for (int i = 0; i < VOICES; i++) m_held[i] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rif.req_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", rif.req_ready); else n_pass++;
        n_checks++; if ({ev_valid, ev_on, ev_steal, off_miss} !== 4'b0000) $display("FAIL rst_strobes: got %b expected 0000", {ev_valid, ev_on, ev_steal, off_miss}); else n_pass++;
        n_checks++; if ({ev_voice, ev_key, ev_vel} !== 17'd0) $display("FAIL rst_data: got %h expected 0", {ev_voice, ev_key, ev_vel}); else n_pass++;
        n_checks++; if (keys_on !== 4'b0000 || active_keys !== 3'd0) $display("FAIL rst_keys: got %b/%0d expected 0000/0", keys_on, active_keys); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        send(1'b1, 7'd60, 8'd100, -1);
        n_checks++; if (keys_on !== 4'b0001 || active_keys !== 3'd1) $display("FAIL basic: got %b/%0d expected 0001/1", keys_on, active_keys); else n_pass++;
    endtask

    task automatic test_steal();
        do_reset();
        send(1'b1, 7'd60, 8'd100, -1);
        send(1'b1, 7'd62, 8'd100, -1);
        send(1'b1, 7'd64, 8'd100, -1);
        send(1'b1, 7'd65, 8'd100, -1);
        vf = 4'b0000;
        send(1'b1, 7'd67, 8'd90, -1);
        // key register of voice 0 now 67: the note-off must find it there
        send(1'b0, 7'd67, 8'd40, -1);
        n_checks++; if (keys_on !== 4'b1110) $display("FAIL steal_off: got %b expected 1110", keys_on); else n_pass++;
    endtask

    task automatic test_retrigger();
        do_reset();
        send(1'b1, 7'd60, 8'd100, -1);
        send(1'b1, 7'd60, 8'd80, -1);
        n_checks++; if (active_keys !== 3'd1) $display("FAIL retrig_active: got %0d expected 1", active_keys); else n_pass++;
    endtask

    task automatic test_note_off();
        do_reset();
        send(1'b0, 7'd61, 8'd64, -1);
        send(1'b1, 7'd60, 8'd100, -1);
        send(1'b1, 7'd60, 8'd0, -1);
        n_checks++; if (keys_on !== 4'b0000) $display("FAIL vel0_off: got %b expected 0000", keys_on); else n_pass++;
    endtask

    task automatic test_released();
        do_reset();
        send(1'b1, 7'd10, 8'd50, -1);
        send(1'b1, 7'd11, 8'd50, -1);
        send(1'b1, 7'd12, 8'd50, -1);
        send(1'b1, 7'd13, 8'd50, -1);
        send(1'b0, 7'd11, 8'd50, -1);
        send(1'b0, 7'd12, 8'd50, -1);
        vf = 4'b0100;
        send(1'b1, 7'd20, 8'd70, -1);
        send(1'b1, 7'd21, 8'd70, -1);
        n_checks++; if (ev_voice !== 2'd1 || keys_on !== 4'b1111) $display("FAIL released: got v%0d %b expected v1 1111", ev_voice, keys_on); else n_pass++;
    endtask

    task automatic test_clr();
        do_reset();
        send(1'b1, 7'd60, 8'd100, -1);
        send(1'b1, 7'd62, 8'd100, -1);
        send(1'b1, 7'd64, 8'd70, 2);
        // clr_all while idle: ready drops that same cycle
        send(1'b1, 7'd66, 8'd30, -1);
        clr_all = 1'b1;
        #1;
        n_checks++; if (rif.req_ready !== 1'b0) $display("FAIL clr_idle_ready: got %b expected 0", rif.req_ready); else n_pass++;
        @(negedge sysclk);
        clr_all = 1'b0;
        model_reset_held();
        n_checks++; if (keys_on !== 4'b0000) $display("FAIL clr_idle_keys: got %b expected 0000", keys_on); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        do_reset();
        send(1'b1, 7'd70, 8'd99, -1);
        rif.req_valid = 1'b1; rif.req_on = 1'b1; rif.req_key = 7'd71; rif.req_vel = 8'd88;
        @(posedge sysclk);
        @(negedge sysclk);
        rif.req_valid = 1'b0;
        @(negedge sysclk);
        reset1 = 1'b0;
        #1;
        model_reset();
        n_checks++; if ({ev_valid, ev_on, ev_steal, off_miss} !== 4'b0000) $display("FAIL mid_rst_strobes: got %b expected 0000", {ev_valid, ev_on, ev_steal, off_miss}); else n_pass++;
        n_checks++; if ({ev_voice, ev_key, ev_vel} !== 17'd0) $display("FAIL mid_rst_data: got %h expected 0", {ev_voice, ev_key, ev_vel}); else n_pass++;
        n_checks++; if (keys_on !== 4'b0000 || active_keys !== 3'd0) $display("FAIL mid_rst_keys: got %b/%0d expected 0000/0", keys_on, active_keys); else n_pass++;
        @(negedge sysclk);
        reset1 = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < VOICES + 3; c++) begin
            @(negedge sysclk);
            if (ev_valid === 1'b1 || off_miss === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL mid_rst_event: got %b expected 0", seen); else n_pass++;
    endtask

    task automatic test_random();
        bit on;
        logic [6:0] k;
        logic [7:0] v;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) vf = 4'($urandom);
            on = ($urandom_range(0, 2) != 0);
            k  = 7'(60 + $urandom_range(0, 5));
            v  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
            send(on, k, v, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_steal();
        test_retrigger();
        test_note_off();
        test_released();
        test_clr();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
